pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
- Consumes the lock output of a core PLL and drives that PLL's reset input. It sequences PLL reset, lock acquisition, lock qualification and core reset release.
- Runs on the 74.25 MHz reference clock, which is independent of the PLL output, so it still operates when the PLL is unlocked.
- Sits between the PLL instance and the core's reset tree. Also exposes status and retry/failure indication to the bridge/APF status logic.

Parameters:
- RST_PULSE_CYCLES, 16, cycles pll_rst is held high per reset attempt (>=1)
- LOCK_TIMEOUT_CYCLES, 742500, cycles allowed in WAIT_LOCK before a retry (10 ms at 74.25 MHz)
- LOCK_STABLE_CYCLES, 1024, consecutive synchronized locked cycles required before release (>=1)
- MAX_RETRIES, 3, reset re-attempts after the first before declaring failure (0..255)
- SYNC_STAGES, 2, synchronizer depth for pll_locked (>=2)

Ports:
- clk_74a  in  1  reference clock, also feeds PLL refclk
- reset_n  in  1  asynchronous active-low reset
- pll_locked  in  1  PLL locked, asynchronous to clk_74a
- relock_req  in  1  single-cycle request to restart the full sequence
- pll_rst  out  1  to PLL rst, active high
- core_reset_n  out  1  core reset, active low, registered
- lock_ok  out  1  high only in RUN
- lock_fail  out  1  high only in FAIL
- retry_count  out  8  retries used in the current sequence
- lock_loss_count  out  8  RUN->lock-loss events since reset_n, saturates at 255

Behaviour:
- Reset state (reset_n low, async):
  - state=RESET_PLL, all counters 0, synchronizer flops 0.
  - Outputs: pll_rst=1, core_reset_n=0, lock_ok=0, lock_fail=0, retry_count=0, lock_loss_count=0.
- Deassertion of reset_n is used directly. Asynchronous assertion, synchronous deassertion is the parent's responsibility.
- lk = pll_locked after SYNC_STAGES flops. The FSM samples lk, so FSM reaction to a pll_locked edge is SYNC_STAGES+1 cycles.
- All outputs are registered, decoded from next-state.
- RESET_PLL:
  - pll_rst=1, core_reset_n=0. Cycle counter runs 0..RST_PULSE_CYCLES-1.
  - pll_rst is high exactly RST_PULSE_CYCLES cycles. Then -> WAIT_LOCK, timeout and stable counters cleared.
- WAIT_LOCK:
  - pll_rst=0. Timeout counter increments every cycle.
  - lk=1 -> STABLE.
  - Counter reaches LOCK_TIMEOUT_CYCLES with lk=0:
    - retry_count<MAX_RETRIES -> retry_count+1, -> RESET_PLL.
    - Otherwise -> FAIL.
- STABLE:
  - Stable counter increments while lk=1. The timeout counter keeps running.
  - lk=0 -> back to WAIT_LOCK with the stable counter cleared. Lock bounces must not reset the timeout.
  - Stable counter reaches LOCK_STABLE_CYCLES -> RUN.
  - Timeout expiry while in STABLE is handled exactly as in WAIT_LOCK. Timeout takes priority over qualification in the same cycle.
- RUN:
  - core_reset_n=1, lock_ok=1, pll_rst=0.
  - lk=0 -> core_reset_n=0 and lock_ok=0 on the next edge, lock_loss_count+1 (saturating), retry_count=0, -> RESET_PLL.
- FAIL:
  - pll_rst=0, core_reset_n=0, lock_fail=1. Held until relock_req or reset_n.
- relock_req:
  - In any state: -> RESET_PLL next cycle, retry_count=0, all timers cleared, lock_fail=0, core_reset_n=0.
  - In RUN, relock_req does not increment lock_loss_count.
  - relock_req has priority over every other transition in the same cycle.
- Invariants:
  - core_reset_n=1 only in RUN.
  - pll_rst and core_reset_n are never both 1.
  - Counter widths: $clog2(param+1). No wrap: each counter stops at its terminal value.

Test Plan:
All runs use RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=100, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2, SYNC_STAGES=2.
- Clean lock: release reset_n, raise pll_locked 20 cycles after pll_rst falls and hold it.
  - pll_rst high exactly 4 cycles.
  - core_reset_n and lock_ok rise exactly 2+1+8 cycles after pll_locked rises.
  - retry_count=0.
- Never locks: pll_locked held 0.
  - Three pll_rst pulses of 4 cycles each, separated by 100-cycle waits.
  - retry_count steps 1, 2. lock_fail=1 after the third timeout, core_reset_n stays 0.
- Lock chatter: pll_locked toggles high 5 / low 1 cycles, then holds high at cycle 60 of WAIT_LOCK.
  - No release before 8 consecutive synced highs. Release occurs and the timeout does not fire.
- Lock loss in RUN: drop pll_locked for 1 cycle.
  - core_reset_n=0 at 3 cycles after the drop, lock_loss_count=1, new 4-cycle pll_rst pulse, re-release after relock.
  - Repeat 300 times: lock_loss_count saturates at 255.
- relock_req from FAIL and from RUN:
  - Each gives lock_fail=0, retry_count=0 and a pll_rst pulse the next cycle.
  - From RUN, lock_loss_count is unchanged.
  - relock_req coincident with a timeout: relock wins, retry_count=0.
- Async reset mid-STABLE: assert reset_n low between clock edges.
  - Outputs reach reset values immediately, without waiting for a clock edge.
  - After deassertion the sequence restarts with a 4-cycle pll_rst pulse.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences PLL reset, lock acquisition and lock qualification,
// then releases the core reset. Runs on the free-running 74.25 MHz reference clock.
module pll_lock_supervisor #(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 742500,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES         = 3,
    parameter int unsigned SYNC_STAGES         = 2
) (
    input  logic       clk_74a,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       relock_req,
    output logic       pll_rst,
    output logic       core_reset_n,
    output logic       lock_ok,
    output logic       lock_fail,
    output logic [7:0] retry_count,
    output logic [7:0] lock_loss_count
);
    localparam int RW = $clog2(RST_PULSE_CYCLES + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);
    localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam logic [RW-1:0] RST_LAST  = RW'(RST_PULSE_CYCLES - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX    = TW'(LOCK_TIMEOUT_CYCLES);
    localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [SW-1:0] STAB_MAX  = SW'(LOCK_STABLE_CYCLES);
    localparam logic [7:0]    RETRY_MAX = 8'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [RW-1:0]          rst_cnt_q, rst_cnt_d;
    logic [TW-1:0]          to_cnt_q, to_cnt_d, to_next_s;
    logic [SW-1:0]          stab_cnt_q, stab_cnt_d, stab_next_s;
    logic [7:0]             retry_count_q, retry_count_d;
    logic [7:0]             lock_loss_count_q, lock_loss_count_d;
    logic                   pll_rst_q, pll_rst_d;
    logic                   core_reset_n_q, core_reset_n_d;
    logic                   lock_ok_q, lock_ok_d;
    logic                   lock_fail_q, lock_fail_d;
    logic                   lk_s, to_expire_s, retry_ok_s;

    // Synchronizer shift, saturating counter increments and shared decision terms.
    always_comb begin
        sync_d      = {sync_q[SYNC_STAGES-2:0], pll_locked};
        lk_s        = sync_q[SYNC_STAGES-1];
        to_next_s   = (to_cnt_q == TO_MAX) ? to_cnt_q : to_cnt_q + TW'(1);
        stab_next_s = (stab_cnt_q == STAB_MAX) ? stab_cnt_q : stab_cnt_q + SW'(1);
        to_expire_s = (to_cnt_q >= TO_LAST);
        retry_ok_s  = (retry_count_q < RETRY_MAX);
    end

    // Next-state and counter update; relock_req overrides every other transition.
    always_comb begin
        state_d           = state_q;
        rst_cnt_d         = rst_cnt_q;
        to_cnt_d          = to_cnt_q;
        stab_cnt_d        = stab_cnt_q;
        retry_count_d     = retry_count_q;
        lock_loss_count_d = lock_loss_count_q;
        if (relock_req) begin
            state_d       = S_RESET_PLL;
            rst_cnt_d     = RW'(0);
            to_cnt_d      = TW'(0);
            stab_cnt_d    = SW'(0);
            retry_count_d = 8'd0;
        end else begin
            case (state_q)
                S_RESET_PLL: begin
                    if (rst_cnt_q >= RST_LAST) begin
                        state_d    = S_WAIT_LOCK;
                        rst_cnt_d  = RW'(0);
                        to_cnt_d   = TW'(0);
                        stab_cnt_d = SW'(0);
                    end else begin
                        rst_cnt_d = rst_cnt_q + RW'(1);
                    end
                end
                S_WAIT_LOCK: begin
                    to_cnt_d = to_next_s;
                    if (lk_s) begin
                        state_d    = S_STABLE;
                        stab_cnt_d = SW'(0);
                    end else if (to_expire_s) begin
                        state_d       = retry_ok_s ? S_RESET_PLL : S_FAIL;
                        retry_count_d = retry_ok_s ? retry_count_q + 8'd1 : retry_count_q;
                        rst_cnt_d     = RW'(0);
                    end else begin
                        state_d = S_WAIT_LOCK;
                    end
                end
                S_STABLE: begin
                    // The timeout keeps running through lock bounces and wins over qualification.
                    to_cnt_d = to_next_s;
                    if (to_expire_s) begin
                        state_d       = retry_ok_s ? S_RESET_PLL : S_FAIL;
                        retry_count_d = retry_ok_s ? retry_count_q + 8'd1 : retry_count_q;
                        rst_cnt_d     = RW'(0);
                    end else if (!lk_s) begin
                        state_d    = S_WAIT_LOCK;
                        stab_cnt_d = SW'(0);
                    end else if (stab_cnt_q >= STAB_LAST) begin
                        state_d    = S_RUN;
                        stab_cnt_d = stab_next_s;
                    end else begin
                        stab_cnt_d = stab_next_s;
                    end
                end
                S_RUN: begin
                    if (!lk_s) begin
                        state_d           = S_RESET_PLL;
                        rst_cnt_d         = RW'(0);
                        retry_count_d     = 8'd0;
                        lock_loss_count_d = (lock_loss_count_q == 8'hFF) ? lock_loss_count_q
                                                                         : lock_loss_count_q + 8'd1;
                    end else begin
                        state_d = S_RUN;
                    end
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d   = S_RESET_PLL;
                    rst_cnt_d = RW'(0);
                end
            endcase
        end
    end

    // Output decode from next state so the registered outputs track the state register.
    always_comb begin
        pll_rst_d      = 1'b0;
        core_reset_n_d = 1'b0;
        lock_ok_d      = 1'b0;
        lock_fail_d    = 1'b0;
        case (state_d)
            S_RESET_PLL: pll_rst_d = 1'b1;
            S_WAIT_LOCK: pll_rst_d = 1'b0;
            S_STABLE:    pll_rst_d = 1'b0;
            S_RUN: begin
                core_reset_n_d = 1'b1;
                lock_ok_d      = 1'b1;
            end
            S_FAIL:      lock_fail_d = 1'b1;
            default:     pll_rst_d = 1'b1;
        endcase
    end

    // State, counters, synchronizer and registered outputs.
    always_ff @(posedge clk_74a or negedge reset_n) begin
        if (!reset_n) begin
            state_q           <= S_RESET_PLL;
            sync_q            <= {SYNC_STAGES{1'b0}};
            rst_cnt_q         <= RW'(0);
            to_cnt_q          <= TW'(0);
            stab_cnt_q        <= SW'(0);
            retry_count_q     <= 8'd0;
            lock_loss_count_q <= 8'd0;
            pll_rst_q         <= 1'b1;
            core_reset_n_q    <= 1'b0;
            lock_ok_q         <= 1'b0;
            lock_fail_q       <= 1'b0;
        end else begin
            state_q           <= state_d;
            sync_q            <= sync_d;
            rst_cnt_q         <= rst_cnt_d;
            to_cnt_q          <= to_cnt_d;
            stab_cnt_q        <= stab_cnt_d;
            retry_count_q     <= retry_count_d;
            lock_loss_count_q <= lock_loss_count_d;
            pll_rst_q         <= pll_rst_d;
            core_reset_n_q    <= core_reset_n_d;
            lock_ok_q         <= lock_ok_d;
            lock_fail_q       <= lock_fail_d;
        end
    end

    assign pll_rst         = pll_rst_q;
    assign core_reset_n    = core_reset_n_q;
    assign lock_ok         = lock_ok_q;
    assign lock_fail       = lock_fail_q;
    assign retry_count     = retry_count_q;
    assign lock_loss_count = lock_loss_count_q;
endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: expected values are queued as stimulus
// is applied and popped when the corresponding DUT behaviour is observed.
module tb_pll_lock_supervisor;
    localparam int RST_P      = 4;
    localparam int TO_P       = 100;
    localparam int STAB_P     = 8;
    localparam int MAXR       = 2;
    localparam int SYNC_P     = 2;
    localparam int REL_LAT    = SYNC_P + 1 + STAB_P;  // pll_locked rise to release
    localparam int RELOCK_LAT = 1 + STAB_P;           // lk already high when WAIT_LOCK starts
    localparam int BOUND      = 1000;

    logic       clk_74a    = 1'b0;
    logic       reset_n    = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic       core_reset_n;
    logic       lock_ok;
    logic       lock_fail;
    logic [7:0] retry_count;
    logic [7:0] lock_loss_count;

    int checks    = 0;
    int errors    = 0;
    int inv_viol  = 0;
    int sb_q[$];

    always #5 clk_74a = ~clk_74a;

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES   (RST_P),
        .LOCK_TIMEOUT_CYCLES(TO_P),
        .LOCK_STABLE_CYCLES (STAB_P),
        .MAX_RETRIES        (MAXR),
        .SYNC_STAGES        (SYNC_P)
    ) dut (
        .clk_74a        (clk_74a),
        .reset_n        (reset_n),
        .pll_locked     (pll_locked),
        .relock_req     (relock_req),
        .pll_rst        (pll_rst),
        .core_reset_n   (core_reset_n),
        .lock_ok        (lock_ok),
        .lock_fail      (lock_fail),
        .retry_count    (retry_count),
        .lock_loss_count(lock_loss_count)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input int v);
        sb_q.push_back(v);
    endtask

    task automatic sb_check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        if (sb_q.size() > 0) e = sb_q.pop_front();
        else e = 32'hFFFF_FFFF;
        check_eq(tag, obs, e);
    endtask

    // Counts samples (current one included) while pll_rst is high.
    task automatic meas_rst_high(output int n);
        n = 0;
        while (pll_rst === 1'b1 && n < BOUND) begin
            n++;
            @(negedge clk_74a);
        end
    endtask

    // Counts samples (current one included) with pll_rst low and not failed.
    task automatic meas_wait_low(output int n);
        n = 0;
        while (pll_rst === 1'b0 && lock_fail === 1'b0 && n < BOUND) begin
            n++;
            @(negedge clk_74a);
        end
    endtask

    // Cycles from now until core_reset_n is seen high.
    task automatic cycles_to_release(output int n);
        n = 0;
        do begin
            @(negedge clk_74a);
            n++;
        end while (core_reset_n !== 1'b1 && n < BOUND);
    endtask

    task automatic pulse_relock();
        relock_req = 1'b1;
        @(negedge clk_74a);
        relock_req = 1'b0;
    endtask

    always @(negedge clk_74a) begin
        if (reset_n) begin
            if (pll_rst === 1'b1 && core_reset_n === 1'b1) inv_viol++;
            if (core_reset_n !== lock_ok) inv_viol++;
            if (lock_fail === 1'b1 && core_reset_n === 1'b1) inv_viol++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        int early;
        #3;
        reset_n = 1'b0;
        repeat (3) @(negedge clk_74a);
        sb_push(1); sb_check("rst_pll_rst", pll_rst);
        sb_push(0); sb_check("rst_core_reset_n", core_reset_n);
        sb_push(0); sb_check("rst_lock_ok", lock_ok);
        sb_push(0); sb_check("rst_lock_fail", lock_fail);
        sb_push(0); sb_check("rst_retry", retry_count);
        sb_push(0); sb_check("rst_loss", lock_loss_count);

        // Clean lock
        reset_n = 1'b1;
        sb_push(RST_P); meas_rst_high(n); sb_check("clean_pulse", n);
        repeat (20) @(negedge clk_74a);
        pll_locked = 1'b1;
        sb_push(REL_LAT); cycles_to_release(n); sb_check("clean_release", n);
        sb_push(1); sb_check("clean_lock_ok", lock_ok);
        sb_push(0); sb_check("clean_retry", retry_count);
        sb_push(0); sb_check("clean_pll_rst", pll_rst);

        // Lock loss in RUN, repeated past saturation
        for (int it = 1; it <= 300; it++) begin
            pll_locked = 1'b0;
            @(negedge clk_74a);
            pll_locked = 1'b1;
            @(negedge clk_74a);
            sb_push(1); sb_check("loss_still_run", core_reset_n);
            @(negedge clk_74a);
            sb_push(0); sb_check("loss_core_rst", core_reset_n);
            sb_push((it > 255) ? 255 : it); sb_check("loss_count", lock_loss_count);
            sb_push(0); sb_check("loss_retry", retry_count);
            sb_push(RST_P); meas_rst_high(n); sb_check("loss_pulse", n);
            sb_push(RELOCK_LAT); cycles_to_release(n); sb_check("loss_rerelease", n);
        end

        // relock_req from RUN, with the lock dropping at the same time
        pll_locked = 1'b0;
        pulse_relock();
        sb_push(1);   sb_check("rrun_pll_rst", pll_rst);
        sb_push(0);   sb_check("rrun_core_rst", core_reset_n);
        sb_push(0);   sb_check("rrun_retry", retry_count);
        sb_push(255); sb_check("rrun_loss", lock_loss_count);
        sb_push(RST_P); meas_rst_high(n); sb_check("rrun_pulse", n);

        // Never locks: three attempts then FAIL
        for (int a = 0; a <= MAXR; a++) begin
            sb_push(TO_P); meas_wait_low(n); sb_check("nolock_wait", n);
            if (a < MAXR) begin
                sb_push(a + 1); sb_check("nolock_retry", retry_count);
                sb_push(RST_P); meas_rst_high(n); sb_check("nolock_pulse", n);
            end else begin
                sb_push(1); sb_check("nolock_fail", lock_fail);
                sb_push(0); sb_check("nolock_pll_rst", pll_rst);
                sb_push(MAXR); sb_check("nolock_retry_final", retry_count);
            end
        end
        repeat (10) @(negedge clk_74a);
        sb_push(1);   sb_check("fail_held", lock_fail);
        sb_push(0);   sb_check("fail_core_rst", core_reset_n);
        sb_push(255); sb_check("fail_loss", lock_loss_count);

        // relock_req from FAIL
        pulse_relock();
        sb_push(1); sb_check("rfail_pll_rst", pll_rst);
        sb_push(0); sb_check("rfail_lock_fail", lock_fail);
        sb_push(0); sb_check("rfail_retry", retry_count);
        sb_push(RST_P); meas_rst_high(n); sb_check("rfail_pulse", n);

        // relock_req on the very edge of the final timeout
        for (int a = 0; a < MAXR; a++) begin
            sb_push(TO_P); meas_wait_low(n); sb_check("coinc_wait", n);
            sb_push(RST_P); meas_rst_high(n); sb_check("coinc_pulse", n);
        end
        sb_push(MAXR); sb_check("coinc_retry_before", retry_count);
        repeat (TO_P - 1) @(negedge clk_74a);
        pulse_relock();
        sb_push(0); sb_check("coinc_retry", retry_count);
        sb_push(0); sb_check("coinc_lock_fail", lock_fail);
        sb_push(1); sb_check("coinc_pll_rst", pll_rst);
        sb_push(RST_P); meas_rst_high(n); sb_check("coinc_pulse_after", n);

        // Lock chatter: 5 high / 1 low, then held high from cycle 60 of WAIT_LOCK
        early = 0;
        for (int i = 0; i < 60; i++) begin
            pll_locked = ((i % 6) != 5);
            if (core_reset_n !== 1'b0 || pll_rst !== 1'b0) early++;
            @(negedge clk_74a);
        end
        pll_locked = 1'b1;
        sb_push(0); sb_check("chatter_no_early", early);
        sb_push(REL_LAT); cycles_to_release(n); sb_check("chatter_release", n);
        sb_push(0); sb_check("chatter_retry", retry_count);

        // Async reset in the middle of STABLE
        pll_locked = 1'b0;
        pulse_relock();
        sb_push(RST_P); meas_rst_high(n); sb_check("ar_pulse", n);
        pll_locked = 1'b1;
        repeat (6) @(negedge clk_74a);
        sb_push(0); sb_check("ar_in_stable", core_reset_n);
        @(posedge clk_74a);
        #2;
        reset_n = 1'b0;
        #1;
        sb_push(1); sb_check("ar_pll_rst", pll_rst);
        sb_push(0); sb_check("ar_core_rst", core_reset_n);
        sb_push(0); sb_check("ar_lock_ok", lock_ok);
        sb_push(0); sb_check("ar_lock_fail", lock_fail);
        sb_push(0); sb_check("ar_retry", retry_count);
        sb_push(0); sb_check("ar_loss", lock_loss_count);
        repeat (2) @(negedge clk_74a);
        reset_n = 1'b1;
        sb_push(RST_P); meas_rst_high(n); sb_check("ar_restart_pulse", n);
        sb_push(RELOCK_LAT); cycles_to_release(n); sb_check("ar_rerelease", n);
        sb_push(0); sb_check("ar_loss_after", lock_loss_count);

        check_eq("invariants", inv_viol, 0);
        check_eq("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
